// File: rtl/math_result_fifo.sv
// First-word fall-through result FIFO behind a fixed-latency equation pipeline.
// Define MATH_RESULT_FIFO_DROP_CNT_EN to add the saturating drop_cnt_o counter.
module math_result_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic signed [2*WIDTH+3:0]  q_i,
  output logic                       ready_o,
  output logic                       m_valid_o,
  output logic signed [2*WIDTH+3:0]  m_data_o,
  input  logic                       m_ready_i,
`ifdef MATH_RESULT_FIFO_DROP_CNT_EN
  output logic [7:0]                 drop_cnt_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int RW = 2*WIDTH+4;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW+1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] LATENCY_C = CW'(LATENCY);

  logic signed [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign full = (count == DEPTH_C);
  assign pop  = m_valid_o && m_ready_i;
  assign push = valid_i && (!full || pop);
  assign drop = valid_i && full && !pop;

  assign m_valid_o  = (count != '0);
  assign m_data_o   = mem[rd_ptr];
  assign count_o    = count;
  assign overflow_o = overflow;
  // Reserve room for every result already in flight upstream.
  assign ready_o    = (DEPTH_C - count) > LATENCY_C;

  // NOTE: storage has no reset; entries are only visible through count, so reset
  // of the array would buy nothing but a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= q_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef MATH_RESULT_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`endif

endmodule

// File: doc/math_result_fifo.md
MATH_RESULT_FIFO -- requirements
Module: math_result_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width of the upstream equation pipeline; result width RW = 2*WIDTH+4.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries; power of two and at least LATENCY+1.
REQ-003 SHALL have parameter LATENCY, default 3: upstream issue-to-result latency in cycles, used for the ready threshold.
REQ-004 SHALL have ports: clk  input  1  sole clock, all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 valid_i  input  1  result strobe from the upstream pipeline (no backpressure possible).
REQ-007 q_i  input  RW signed  upstream result.
REQ-008 ready_o  output  1  upstream may issue a new operand set this cycle.
REQ-009 m_valid_o  output  1  head entry available to the consumer.
REQ-010 m_data_o  output  RW signed  head entry data.
REQ-011 m_ready_i  input  1  consumer accepts the head entry.
REQ-012 count_o  output  clog2(DEPTH)+1  current occupancy.
REQ-013 overflow_o  output  1  sticky flag: at least one result was dropped.

Function
REQ-014 Push SHALL occur when valid_i=1 and the FIFO has a free slot or a pop occurs in the same cycle.
REQ-015 Pop SHALL occur when m_valid_o=1 and m_ready_i=1.
REQ-016 m_valid_o SHALL equal (count_o != 0); m_data_o SHALL show the head entry combinationally (first-word fall-through).
REQ-017 A pushed entry SHALL become visible on m_valid_o/m_data_o on the cycle after the push; there SHALL be no same-cycle bypass.
REQ-018 count_o SHALL change per cycle as follows: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
REQ-019 Read and write pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
REQ-020 When full with no pop in the same cycle, valid_i=1 SHALL drop q_i, set overflow_o, and leave contents and pointers unchanged.
REQ-021 When full with a pop in the same cycle, valid_i=1 SHALL be accepted; count_o stays at DEPTH.
REQ-022 When empty, m_ready_i SHALL be ignored and no pop SHALL occur.
REQ-023 ready_o SHALL be combinational: 1 iff (DEPTH - count_o) > LATENCY.
- This guarantees no overflow while upstream issues only when ready_o=1.
REQ-024 overflow_o SHALL stay set until reset and SHALL be unaffected by later pops.
REQ-025 Data SHALL be stored and returned bit-exact, with sign preserved and no rounding or truncation.
REQ-026 Output ordering SHALL be strict FIFO order of acceptance.

Reset
REQ-027 On rst=0 at a clock edge, pointers SHALL be 0, count_o 0, m_valid_o 0, overflow_o 0, and ready_o 1.
REQ-028 Storage array contents SHALL NOT be reset; m_data_o is don't-care while m_valid_o=0.
REQ-029 Reset mid-operation SHALL discard all stored entries; valid_i during reset SHALL be ignored.

Configuration
REQ-030 Macro MATH_RESULT_FIFO_DROP_CNT_EN defined SHALL add output drop_cnt_o [7:0].
- Increments on each dropped result (REQ-020).
- Saturates at 255.
- Reset to 0.
REQ-031 Without MATH_RESULT_FIFO_DROP_CNT_EN, drop_cnt_o and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset, then push 3 results (-5, 0, 131071) with m_ready_i=0 -> count_o=3; first data appears on m_valid_o the cycle after the first push; m_ready_i=1 returns -5, 0, 131071 in order.
REQ-033 DEPTH=8, LATENCY=3: push 4 with no pop -> ready_o=1 at count 4, 0 at count 5; pop 1 -> ready_o=1.
REQ-034 Fill to 8, then valid_i=1 with m_ready_i=0 -> data dropped, overflow_o=1, count_o=8; drop_cnt_o=1 with macro.
REQ-035 Full, then valid_i=1 with m_ready_i=1 in the same cycle -> count_o stays 8, the new value is read out last, overflow_o stays 0.
REQ-036 Stream 20 results with continuous pops and random m_ready_i stalls -> pointer wrap, order preserved, no loss while upstream obeys ready_o.
REQ-037 Assert rst=0 with 5 entries stored -> next cycle count_o=0, m_valid_o=0, overflow_o=0; subsequent push works from slot 0.
